hwpf_nl_engine: RTL and testbench



---
 rtl/hwpf_nl_engine.sv | 140 ++++++++++++++
 tb/tb_hwpf_nl_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpf_nl_engine.sv
// Next-line prefetch candidate generator and issuer for the hwpf_nl prefetcher.
// Captures demand misses, filters next-line candidates and issues them from a pending queue.
module hwpf_nl_engine #(
    parameter int unsigned QUEUE_DEPTH = 3,
    parameter int unsigned INSERTS     = 2,
    parameter int unsigned LINE_BYTES  = 64,
    parameter int unsigned PENDING     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         lock_i,
    input  logic                         miss_valid_i,
    input  logic [39:0]                  miss_addr_i,
    input  logic [QUEUE_DEPTH-1:0][39:0] fifo_data_cpu_i,
    input  logic [QUEUE_DEPTH-1:0]       fifo_data_valid_i,
    output logic [INSERTS-1:0]           take_req_o,
    output logic [INSERTS-1:0][39:0]     cpu_req_o,
    output logic                         pf_valid_o,
    output logic [39:0]                  pf_addr_o,
    input  logic                         pf_ready_i,
    output logic                         busy_o
);

    localparam int unsigned AW = 40;
    localparam int unsigned PW = (PENDING > 1) ? $clog2(PENDING) : 1;
    localparam int unsigned CW = $clog2(PENDING + 1);
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_BYTES - 1);

    logic                        s1_valid;
    logic [AW-1:0]               s1_base;
    logic [AW-1:0]               q [PENDING];
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [PW-1:0]               tail_nxt;
    logic [CW-1:0]               count;
    logic [INSERTS-1:0][AW-1:0]  cand;
    logic [INSERTS-1:0]          keep;
    logic [PENDING-1:0]          slot_vld;
    logic [PW-1:0]               push_idx [INSERTS];
    logic                        capture;
    logic                        pop;
    int                          n_push;

    assign capture = miss_valid_i & ~lock_i & ~flush_i;

    // A slot is live when its distance from head is below the count.
    always_comb begin
        int off;
        off = 0;
        for (int i = 0; i < int'(PENDING); i++) begin
            if (i >= int'(head)) off = i - int'(head);
            else off = i + int'(PENDING) - int'(head);
            slot_vld[i] = (off < int'(count));
        end
    end

    always_comb begin
        for (int k = 0; k < int'(INSERTS); k++) begin
            cand[k] = s1_base + AW'((k + 1) * LINE_BYTES);
            keep[k] = (cand[k][AW-1:12] == s1_base[AW-1:12]);
            for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
                if (fifo_data_valid_i[j] && fifo_data_cpu_i[j] == cand[k])
                    keep[k] = 1'b0;
            end
            for (int i = 0; i < int'(PENDING); i++) begin
                if (slot_vld[i] && q[i] == cand[k])
                    keep[k] = 1'b0;
            end
        end
    end

    // Grants go in ascending k order against space seen before any pop.
    always_comb begin
        int free_slots;
        int rank;
        int slot;
        free_slots = int'(PENDING) - int'(count);
        rank       = 0;
        slot       = 0;
        for (int k = 0; k < int'(INSERTS); k++) begin
            take_req_o[k] = 1'b0;
            push_idx[k]   = '0;
            cpu_req_o[k]  = s1_valid ? cand[k] : '0;
            if (s1_valid && keep[k] && !flush_i && rank < free_slots) begin
                take_req_o[k] = 1'b1;
                slot = int'(tail) + rank;
                if (slot >= int'(PENDING)) slot = slot - int'(PENDING);
                push_idx[k] = PW'(slot);
                rank = rank + 1;
            end
        end
        n_push = rank;
        slot = int'(tail) + rank;
        if (slot >= int'(PENDING)) slot = slot - int'(PENDING);
        tail_nxt = PW'(slot);
    end

    assign pf_valid_o = (count != '0);
    assign pf_addr_o  = pf_valid_o ? q[head] : '0;
    assign busy_o     = s1_valid | pf_valid_o;
    assign pop        = pf_valid_o & pf_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) s1_base <= miss_addr_i & LINE_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= (head == PW'(PENDING - 1)) ? '0 : head + PW'(1);
            tail  <= tail_nxt;
            count <= CW'(int'(count) + n_push - int'(pop));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PENDING); i++) q[i] <= '0;
        end else begin
            for (int k = 0; k < int'(INSERTS); k++) begin
                if (take_req_o[k]) q[push_idx[k]] <= cand[k];
            end
        end
    end

endmodule

// File: tb/tb_hwpf_nl_engine.sv
// Bench for hwpf_nl_engine: directed vector table plus randomized
// traffic against a queue-based reference model.
module tb_hwpf_nl_engine;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush = 1'b0;
    logic            lock = 1'b0;
    logic            mv = 1'b0;
    logic            rdy = 1'b0;
    logic [39:0]     ma = '0;
    logic [2:0][39:0] fd = '0;
    logic [2:0]      fv = '0;
    logic [1:0]      take;
    logic [1:0][39:0] cpu;
    logic            pv;
    logic [39:0]     pa;
    logic            busy;

    int checks = 0;
    int errors = 0;

    hwpf_nl_engine dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_i           (flush),
        .lock_i            (lock),
        .miss_valid_i      (mv),
        .miss_addr_i       (ma),
        .fifo_data_cpu_i   (fd),
        .fifo_data_valid_i (fv),
        .take_req_o        (take),
        .cpu_req_o         (cpu),
        .pf_valid_o        (pv),
        .pf_addr_o         (pa),
        .pf_ready_i        (rdy),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: S1 as a flag + line base, pending queue as a queue.
    bit          m_v = 1'b0;
    logic [39:0] m_base = '0;
    logic [39:0] mq[$];
    logic [39:0] m_push[$];
    logic [1:0]  e_take;
    logic [1:0][39:0] e_cpu;
    logic        e_pv;
    logic [39:0] e_pa;
    logic        e_busy;

    function automatic bit in_q(logic [39:0] a);
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_fifo(logic [39:0] a);
        for (int j = 0; j < 3; j++) if (fv[j] && fd[j] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_expect();
        logic [39:0] c;
        int room;
        m_push.delete();
        room = 4 - mq.size();
        for (int k = 0; k < 2; k++) begin
            c = m_base + 40'((k + 1) * 64);
            e_cpu[k] = m_v ? c : 40'h0;
            e_take[k] = 1'b0;
            if (m_v && !flush && c[39:12] == m_base[39:12] && !in_fifo(c)
                && !in_q(c) && m_push.size() < room) begin
                e_take[k] = 1'b1;
                m_push.push_back(c);
            end
        end
        e_pv = (mq.size() != 0);
        e_pa = e_pv ? mq[0] : 40'h0;
        e_busy = m_v || e_pv;
    endtask

    task automatic model_step();
        if (flush) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            if (e_pv && rdy) void'(mq.pop_front());
            foreach (m_push[i]) mq.push_back(m_push[i]);
            m_v = mv && !lock;
            if (m_v) m_base = ma & ~40'h3f;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic run_cycle();
        #1;
        model_expect();
        chk("model_take", 64'(take), 64'(e_take));
        chk("model_cpu0", 64'(cpu[0]), 64'(e_cpu[0]));
        chk("model_cpu1", 64'(cpu[1]), 64'(e_cpu[1]));
        chk("model_pf_valid", 64'(pv), 64'(e_pv));
        chk("model_pf_addr", 64'(pa), 64'(e_pa));
        chk("model_busy", 64'(busy), 64'(e_busy));
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit          mv;
        logic [39:0] ma;
        bit          lk;
        bit          fl;
        bit          rdy;
        logic [39:0] f0;
        bit          fv0;
        logic [1:0]  e_take;
        bit          e_pv;
        logic [39:0] e_pa;
        bit          e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit m, logic [39:0] a, bit lk, bit fl,
                                bit r, logic [39:0] f0, bit fv0,
                                logic [1:0] et, bit ep, logic [39:0] ea,
                                bit eb);
        vec_t v;
        v.mv = m; v.ma = a; v.lk = lk; v.fl = fl; v.rdy = r;
        v.f0 = f0; v.fv0 = fv0;
        v.e_take = et; v.e_pv = ep; v.e_pa = ea; v.e_busy = eb;
        return v;
    endfunction

    function automatic logic [27:0] rnd_page();
        case ($urandom_range(0, 4))
            0: return 28'h0;
            1: return 28'h1;
            2: return 28'h2;
            3: return 28'hfffffff;
            default: return 28'h3;
        endcase
    endfunction

    initial begin
        // basic miss
        tbl.push_back(mk(1, 40'hCAFE0010, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'hCAFE0040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'hCAFE0080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        // fifo filter
        tbl.push_back(mk(1, 40'hCAFE0000, 0, 0, 1, 40'hCAFE0040, 1, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 40'hCAFE0040, 1, 2'b10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'hCAFE0080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        // page boundary
        tbl.push_back(mk(1, 40'hCAFE0F80, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 40'hCAFE0FC0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'hCAFE0FC0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        // backpressure and overflow
        tbl.push_back(mk(1, 40'h1000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 40'h2000, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1));
        tbl.push_back(mk(1, 40'h3000, 0, 0, 0, 0, 0, 2'b11, 1, 40'h1040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 40'h1040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 40'h1040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'h1040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'h1080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'h2040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 40'h2080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        // duplicate pending
        tbl.push_back(mk(1, 40'h1000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 40'h1040, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 40'h1040, 1));
        // flush with a live S1 and a simultaneous miss
        tbl.push_back(mk(1, 40'h6000, 0, 0, 0, 0, 0, 2'b00, 1, 40'h1040, 1));
        tbl.push_back(mk(1, 40'h4000, 0, 1, 0, 0, 0, 2'b00, 1, 40'h1040, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        // lock blocks capture, pending entries still issue
        tbl.push_back(mk(1, 40'h7000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1));
        tbl.push_back(mk(1, 40'h5000, 1, 0, 0, 0, 0, 2'b00, 1, 40'h7040, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 40'h7040, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 40'h7080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        // miss already in S1 completes under lock
        tbl.push_back(mk(1, 40'h8000, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 40'h9000, 1, 0, 1, 0, 0, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 40'h8040, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 40'h8080, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_take", 64'(take), 64'h0);
        chk("rst_cpu0", 64'(cpu[0]), 64'h0);
        chk("rst_cpu1", 64'(cpu[1]), 64'h0);
        chk("rst_pf_valid", 64'(pv), 64'h0);
        chk("rst_pf_addr", 64'(pa), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            mv = tbl[i].mv; ma = tbl[i].ma; lock = tbl[i].lk;
            flush = tbl[i].fl; rdy = tbl[i].rdy;
            fd = '0; fv = '0;
            fd[0] = tbl[i].f0; fv[0] = tbl[i].fv0;
            #1;
            chk($sformatf("vec%0d_take", i), 64'(take), 64'(tbl[i].e_take));
            chk($sformatf("vec%0d_pf_valid", i), 64'(pv), 64'(tbl[i].e_pv));
            chk($sformatf("vec%0d_pf_addr", i), 64'(pa), 64'(tbl[i].e_pa));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            run_cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            mv = ($urandom_range(0, 1) == 1);
            ma = {rnd_page(), 6'($urandom_range(0, 63)), 6'($urandom)};
            lock = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < 3; j++) begin
                fd[j] = {rnd_page(), 6'($urandom_range(0, 63)), 6'h0};
                fv[j] = ($urandom_range(0, 1) == 1);
            end
            run_cycle();
        end

        // fill the queue, then reset asynchronously mid-cycle
        flush = 1'b0; lock = 1'b0; rdy = 1'b0; fv = '0;
        for (int n = 0; n < 3; n++) begin
            mv = 1'b1;
            ma = 40'(40'hA000 + 40'(n) * 40'h1000);
            run_cycle();
        end
        mv = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_take", 64'(take), 64'h0);
        chk("arst_pf_valid", 64'(pv), 64'h0);
        chk("arst_pf_addr", 64'(pa), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        mq.delete();
        m_v = 1'b0;
        m_base = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        rdy = 1'b1;
        for (int n = 0; n < 4; n++) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
